// File: rtl/fifo_rd_pkg.sv
// rtl/fifo_rd_pkg.sv - shared constants and elaboration helpers for the FIFO read-side unpacker
package fifo_rd_pkg;

  localparam int BUF_DEPTH = 2;

  // Width of the beat counter; a RATIO of 2 still needs one bit.
  function automatic int beat_w(input int ratio);
    return (ratio <= 2) ? 1 : $clog2(ratio);
  endfunction

  function automatic bit cfg_ok(input int data_w, input int out_w);
    return (out_w > 0) && ((data_w % out_w) == 0) && ((data_w / out_w) >= 2);
  endfunction

endpackage

// File: rtl/fifo_rd_unpacker_if.sv
// rtl/fifo_rd_unpacker_if.sv - FIFO read port plus narrow output stream bundle
interface fifo_rd_unpacker_if #(
  parameter int DATA_W = 128,
  parameter int OUT_W  = 32
) ();

  logic              r_en;
  logic              r_empty;
  logic [DATA_W-1:0] rdata;
  logic              m_valid;
  logic              m_ready;
  logic [OUT_W-1:0]  m_data;
  logic              m_last;
  logic              busy;

  modport master (
    output r_en, m_valid, m_data, m_last, busy,
    input  r_empty, rdata, m_ready
  );

  modport slave (
    input  r_en, m_valid, m_data, m_last, busy,
    output r_empty, rdata, m_ready
  );

endinterface

// File: rtl/fifo_rd_wbuf.sv
// rtl/fifo_rd_wbuf.sv - two-entry word store with wrapping 1-bit pointers and occupancy
module fifo_rd_wbuf
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic [1:0]        occ,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] r_slot [BUF_DEPTH];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_occ;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (push) r_wr_ptr <= ~r_wr_ptr;
      if (pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({push, pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Payload is left unreset; occupancy alone decides what is meaningful.
  always_ff @(posedge clk) begin
    if (push) r_slot[r_wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(pop && (r_occ == 2'd0)))
        else $error("fifo_rd_wbuf: pop while empty");
    end
  end

  assign rd_data = r_slot[r_rd_ptr];
  assign occ     = r_occ;
  assign full    = (r_occ == 2'd2);
  assign empty   = (r_occ == 2'd0);

endmodule

// File: rtl/fifo_rd_unpacker.sv
// rtl/fifo_rd_unpacker.sv - pulls wide FIFO words and emits them as narrow beats, LS slice first
module fifo_rd_unpacker
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int OUT_W  = 32
) (
  input  logic                 r_clk,
  input  logic                 r_rst_n,
  fifo_rd_unpacker_if.master   bus
);

  localparam int RATIO = DATA_W / OUT_W;
  localparam int BW    = beat_w(RATIO);

  if (!cfg_ok(DATA_W, OUT_W)) begin : g_cfg_err
    $error("fifo_rd_unpacker: DATA_W must be a multiple of OUT_W with RATIO >= 2");
  end

  logic              r_pend;
  logic [BW-1:0]     r_beat;

  logic [DATA_W-1:0] w_rd_word;
  logic [1:0]        w_occ;
  logic              w_full;
  logic              w_empty;
  logic              w_credit;
  logic              w_r_en;
  logic              w_valid;
  logic              w_last;
  logic              w_fire;
  logic              w_pop;
  logic [OUT_W-1:0]  w_slice [RATIO];

  // A word is only requested when a slot is guaranteed for it, counting the
  // read already in flight; a pop in the same cycle is deliberately ignored.
  assign w_credit = (({1'b0, w_occ} + {2'b00, r_pend}) < 3'd2);
  assign w_r_en   = r_rst_n && !bus.r_empty && w_credit;

  assign w_valid  = r_rst_n && !w_empty;
  assign w_last   = w_valid && (r_beat == BW'(RATIO - 1));
  assign w_fire   = w_valid && bus.m_ready;
  assign w_pop    = w_fire && w_last;

  for (genvar g = 0; g < RATIO; g++) begin : g_slice
    assign w_slice[g] = w_rd_word[g*OUT_W +: OUT_W];
  end

  always_ff @(posedge r_clk) begin
    if (!r_rst_n) begin
      r_pend <= 1'b0;
      r_beat <= '0;
    end else begin
      r_pend <= w_r_en;
      if (w_fire) r_beat <= w_last ? '0 : r_beat + 1'b1;
    end
  end

  always_ff @(posedge r_clk) begin
    if (r_rst_n) begin
      assert (!(r_pend && w_full && !w_pop))
        else $error("fifo_rd_unpacker: capture into full word buffer");
    end
  end

  fifo_rd_wbuf #(
    .DATA_W (DATA_W)
  ) u_wbuf (
    .clk       (r_clk),
    .rst_n     (r_rst_n),
    .push      (r_pend),
    .push_data (bus.rdata),
    .pop       (w_pop),
    .rd_data   (w_rd_word),
    .occ       (w_occ),
    .full      (w_full),
    .empty     (w_empty)
  );

  assign bus.r_en    = w_r_en;
  assign bus.m_valid = w_valid;
  assign bus.m_data  = w_valid ? w_slice[r_beat] : '0;
  assign bus.m_last  = w_last;
  assign bus.busy    = r_rst_n && (!w_empty || r_pend);

endmodule

// File: tb/tb_fifo_rd_unpacker.sv
// tb/tb_fifo_rd_unpacker.sv - directed self-checking bench for fifo_rd_unpacker
module tb_fifo_rd_unpacker;

  logic clk;
  logic r_rst_n;

  fifo_rd_unpacker_if #(.DATA_W(128), .OUT_W(32)) bus ();

  fifo_rd_unpacker #(.DATA_W(128), .OUT_W(32)) dut (
    .r_clk   (clk),
    .r_rst_n (r_rst_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // FIFO read-port model: one-cycle read latency, restarts empty on reset.
  logic [127:0] mem [256];
  int wr_idx = 0;
  int rd_idx = 0;
  int nxt;

  always @(posedge clk) begin
    nxt = rd_idx;
    if (!r_rst_n) begin
      nxt = wr_idx;
    end else if (bus.r_en) begin
      bus.rdata <= mem[rd_idx[7:0]];
      nxt = rd_idx + 1;
    end
    rd_idx      <= nxt;
    bus.r_empty <= (nxt == wr_idx);
  end

  // Output monitor, sampling well after the falling edge.
  logic [31:0] obs_d [$];
  bit          obs_l [$];
  int          obs_c [$];
  int cyc = 0, n_ren = 0, n_valid = 0, n_busy = 0, n_bad_ren = 0;

  always @(negedge clk) begin
    #2;
    cyc++;
    if (bus.r_en) n_ren++;
    if (bus.r_en && bus.r_empty) n_bad_ren++;
    if (bus.m_valid) n_valid++;
    if (bus.busy) n_busy++;
    if (bus.m_valid && bus.m_ready) begin
      obs_d.push_back(bus.m_data);
      obs_l.push_back(bus.m_last);
      obs_c.push_back(cyc);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_word(input logic [127:0] w);
    mem[wr_idx[7:0]] = w;
    wr_idx = wr_idx + 1;
  endtask

  task automatic wait_beats(input string tag, input int n, input int budget);
    int k = 0;
    while (obs_d.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    #5;
    check(tag, obs_d.size(), n);
  endtask

  logic [127:0] w;
  logic [31:0]  exp_q [$];
  int b, r0, v0, bz0, bad, gaps;

  initial begin
    r_rst_n     = 1'b0;
    bus.m_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_r_en",    bus.r_en,    0);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_last",  bus.m_last,  0);
    check("rst_m_data",  bus.m_data,  0);
    check("rst_busy",    bus.busy,    0);
    @(negedge clk);
    r_rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single word, ready held high
    b = obs_d.size(); r0 = n_ren;
    bus.m_ready = 1'b1;
    push_word(128'h44444444_33333333_22222222_11111111);
    wait_beats("t1_count", b + 4, 30);
    repeat (3) @(negedge clk);
    #3;
    check("t1_ren", n_ren - r0, 1);
    check("t1_d0", obs_d[b+0], 32'h11111111);
    check("t1_d1", obs_d[b+1], 32'h22222222);
    check("t1_d2", obs_d[b+2], 32'h33333333);
    check("t1_d3", obs_d[b+3], 32'h44444444);
    check("t1_lasts", {obs_l[b+0], obs_l[b+1], obs_l[b+2], obs_l[b+3]}, 4'b0001);
    check("t1_consec", obs_c[b+3] - obs_c[b+0], 3);
    check("t1_valid_after", bus.m_valid, 0);
    check("t1_busy_after",  bus.busy,    0);

    // Empty FIFO for 50 cycles
    r0 = n_ren; v0 = n_valid; bz0 = n_busy;
    repeat (50) @(negedge clk);
    #5;
    check("t2_ren",   n_ren - r0,    0);
    check("t2_valid", n_valid - v0,  0);
    check("t2_busy",  n_busy - bz0,  0);

    // Backpressure with five queued words
    b = obs_d.size(); r0 = n_ren;
    bus.m_ready = 1'b0;
    for (int k = 1; k <= 5; k++) push_word(128'(k));
    repeat (15) @(negedge clk);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #3;
      if (!bus.m_valid || bus.m_data !== 32'h1 || bus.r_en) bad++;
    end
    check("t3_ren", n_ren - r0, 2);
    check("t3_hold", bad, 0);
    check("t3_busy", bus.busy, 1);
    @(negedge clk);
    bus.m_ready = 1'b1;
    wait_beats("t3_count", b + 20, 200);
    for (int j = 0; j < 20; j++) begin
      check($sformatf("t3_d%0d", j), obs_d[b+j], (j % 4 == 0) ? 32'(j / 4 + 1) : 32'h0);
      check($sformatf("t3_l%0d", j), obs_l[b+j], (j % 4 == 3) ? 1'b1 : 1'b0);
    end

    // Streaming sixteen words without bubbles
    repeat (5) @(negedge clk);
    b = obs_d.size();
    for (int k = 0; k < 16; k++)
      push_word({32'(k + 7000), 32'(k + 5000), 32'(k + 3000), 32'(k + 100)});
    wait_beats("t4_count", b + 64, 300);
    gaps = 0; bad = 0;
    for (int j = 0; j < 64; j++) begin
      if (j > 0 && obs_c[b+j] != obs_c[b+j-1] + 1) gaps++;
      case (j % 4)
        0: if (obs_d[b+j] !== 32'(j / 4 + 100))  bad++;
        1: if (obs_d[b+j] !== 32'(j / 4 + 3000)) bad++;
        2: if (obs_d[b+j] !== 32'(j / 4 + 5000)) bad++;
        default: if (obs_d[b+j] !== 32'(j / 4 + 7000)) bad++;
      endcase
      if (obs_l[b+j] != (j % 4 == 3)) bad++;
    end
    check("t4_gaps", gaps, 0);
    check("t4_data", bad, 0);

    // Random ready over 32 random words
    repeat (5) @(negedge clk);
    b = obs_d.size();
    for (int k = 0; k < 32; k++) begin
      w = {$urandom, $urandom, $urandom, $urandom};
      push_word(w);
      for (int s = 0; s < 4; s++) exp_q.push_back(w[s*32 +: 32]);
    end
    for (int k = 0; k < 2000 && obs_d.size() < b + 128; k++) begin
      @(negedge clk);
      bus.m_ready = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    bus.m_ready = 1'b1;
    wait_beats("t5_count", b + 128, 50);
    bad = 0;
    for (int j = 0; j < 128; j++) begin
      if (obs_d[b+j] !== exp_q[j]) bad++;
      if (obs_l[b+j] != (j % 4 == 3)) bad++;
    end
    check("t5_data", bad, 0);
    check("t5_ren_empty", n_bad_ren, 0);

    // Reset in the middle of a word
    repeat (5) @(negedge clk);
    b = obs_d.size();
    push_word({32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA});
    push_word({32'h99999999, 32'h88888888, 32'h77777777, 32'h66666666});
    for (int k = 0; k < 30 && obs_d.size() < b + 2; k++) @(negedge clk);
    r_rst_n = 1'b0;
    #1;
    check("t6_pre", obs_d.size(), b + 2);
    check("t6_rst_valid0", bus.m_valid, 0);
    check("t6_rst_ren0",   bus.r_en,    0);
    @(negedge clk);
    #1;
    check("t6_rst_valid1", bus.m_valid, 0);
    check("t6_rst_ren1",   bus.r_en,    0);
    @(negedge clk);
    r_rst_n = 1'b1;
    #1;
    check("t6_rel_valid", bus.m_valid, 0);
    @(posedge clk);
    #1;
    check("t6_rel_valid_next", bus.m_valid, 0);
    #5;
    check("t6_no_beats", obs_d.size(), b + 2);
    @(negedge clk);
    b = obs_d.size();
    push_word({32'hA5A50003, 32'hA5A50002, 32'hA5A50001, 32'hA5A50000});
    push_word({32'hA5A50013, 32'hA5A50012, 32'hA5A50011, 32'hA5A50010});
    wait_beats("t6_count", b + 8, 60);
    check("t6_d0", obs_d[b+0], 32'hA5A50000);
    check("t6_d1", obs_d[b+1], 32'hA5A50001);
    check("t6_d3", obs_d[b+3], 32'hA5A50003);
    check("t6_d4", obs_d[b+4], 32'hA5A50010);
    check("t6_d7", obs_d[b+7], 32'hA5A50013);
    check("t6_lasts", {obs_l[b+0], obs_l[b+1], obs_l[b+2], obs_l[b+3],
                       obs_l[b+4], obs_l[b+5], obs_l[b+6], obs_l[b+7]}, 8'b0001_0001);
    repeat (4) @(negedge clk);
    #3;
    check("t6_busy_end", bus.busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
